// File: rtl/mips_isa_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_isa_pkg
//  Purpose  : MIPS opcode/funct encodings, field slices and write-back kinds.
//  Revision : 1.0  initial release
// ============================================================================
package mips_isa_pkg;

    localparam int OP_HI = 31;
    localparam int OP_LO = 26;
    localparam int RS_HI = 25;
    localparam int RS_LO = 21;
    localparam int RT_HI = 20;
    localparam int RT_LO = 16;
    localparam int RD_HI = 15;
    localparam int RD_LO = 11;
    localparam int FN_HI = 5;
    localparam int FN_LO = 0;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2B;

    localparam logic [5:0] FN_SLL   = 6'h00;
    localparam logic [5:0] FN_SRL   = 6'h02;
    localparam logic [5:0] FN_SRA   = 6'h03;
    localparam logic [5:0] FN_SLLV  = 6'h04;
    localparam logic [5:0] FN_SRLV  = 6'h06;
    localparam logic [5:0] FN_SRAV  = 6'h07;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_MULTU = 6'h19;
    localparam logic [5:0] FN_DIV   = 6'h1A;
    localparam logic [5:0] FN_DIVU  = 6'h1B;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_XOR   = 6'h26;
    localparam logic [5:0] FN_NOR   = 6'h27;
    localparam logic [5:0] FN_SLT   = 6'h2A;
    localparam logic [5:0] FN_SLTU  = 6'h2B;

    typedef enum logic [1:0] {
        WB_NONE = 2'd0,
        WB_GPR  = 2'd1,
        WB_HILO = 2'd2,
        WB_TRAP = 2'd3
    } wb_kind_e;

endpackage
`default_nettype wire

// File: rtl/mips_wb_decode.sv
`default_nettype none
// ============================================================================
//  Module   : mips_wb_decode
//  Purpose  : Combinational write-back destination decode (kind + dest reg).
//  Revision : 1.0  initial release
// ============================================================================
module mips_wb_decode
    import mips_isa_pkg::*;
(
    input  logic [31:0] instr,
    input  logic        overflow,
    output wb_kind_e    kind,
    output logic [4:0]  dest
);

    logic [5:0] w_op;
    logic [5:0] w_fn;
    logic       w_unused_bits;

    assign w_op          = instr[OP_HI:OP_LO];
    assign w_fn          = instr[FN_HI:FN_LO];
    assign w_unused_bits = ^{instr[RS_HI:RS_LO], instr[10:6]};

    always_comb begin
        kind = WB_NONE;
        dest = 5'd0;
        if (w_op == OP_SPECIAL) begin
            case (w_fn)
                FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
                FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV: begin
                    kind = WB_GPR;
                    dest = instr[RD_HI:RD_LO];
                    // Only the signed add/sub trap; the unsigned forms ignore the flag.
                    if (overflow && (w_fn == FN_ADD || w_fn == FN_SUB))
                        kind = WB_TRAP;
                end
                FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: kind = WB_HILO;
                default: kind = WB_NONE;
            endcase
        end else begin
            case (w_op)
                OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
                    kind = WB_GPR;
                    dest = instr[RT_HI:RT_LO];
                    if (overflow && (w_op == OP_ADDI))
                        kind = WB_TRAP;
                end
                default: kind = WB_NONE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_regfile_wb.sv
`default_nettype none
// ============================================================================
//  Module   : mips_regfile_wb
//  Purpose  : Write-back stage: one-entry pending commit into GPRs and hi/lo,
//             bypassed operand reads, sticky overflow trap, retire counter.
//  Revision : 1.0  initial release
// ============================================================================
module mips_regfile_wb
    import mips_isa_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wb_valid,
    input  logic [31:0]      wb_instr,
    input  logic [31:0]      wb_result,
    input  logic [31:0]      wb_hi,
    input  logic [31:0]      wb_lo,
    input  logic             wb_overflow,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      gr1,
    output logic [31:0]      gr2,
    output logic [31:0]      hi_q,
    output logic [31:0]      lo_q,
    output logic             ovf_trap,
    input  logic             trap_clr,
    output logic [CNT_W-1:0] retired_cnt
);

    wb_kind_e    w_kind;
    logic [4:0]  w_dest;

    logic        r_pend_valid;
    wb_kind_e    r_pend_kind;
    logic [4:0]  r_pend_dest;
    logic [31:0] r_pend_data;
    logic [31:0] r_pend_hi;
    logic [31:0] r_pend_lo;

    logic [31:0] r_gpr [NREG];

    mips_wb_decode u_decode (
        .instr    (wb_instr),
        .overflow (wb_overflow),
        .kind     (w_kind),
        .dest     (w_dest)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_valid <= 1'b0;
            r_pend_kind  <= WB_NONE;
            r_pend_dest  <= 5'd0;
            r_pend_data  <= 32'd0;
            r_pend_hi    <= 32'd0;
            r_pend_lo    <= 32'd0;
        end else begin
            r_pend_valid <= wb_valid;
            if (wb_valid) begin
                r_pend_kind <= w_kind;
                r_pend_dest <= w_dest;
                r_pend_data <= wb_result;
                r_pend_hi   <= wb_hi;
                r_pend_lo   <= wb_lo;
            end
        end
    end

    // Commit side: architectural state only changes from the pending entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                r_gpr[i] <= 32'd0;
            hi_q        <= 32'd0;
            lo_q        <= 32'd0;
            ovf_trap    <= 1'b0;
            retired_cnt <= '0;
        end else begin
            if (r_pend_valid && r_pend_kind == WB_TRAP)
                ovf_trap <= 1'b1;
            else if (trap_clr)
                ovf_trap <= 1'b0;

            if (r_pend_valid) begin
                if (r_pend_kind != WB_TRAP)
                    retired_cnt <= retired_cnt + CNT_W'(1);
                if (r_pend_kind == WB_GPR && r_pend_dest != 5'd0)
                    r_gpr[r_pend_dest] <= r_pend_data;
                if (r_pend_kind == WB_HILO) begin
                    hi_q <= r_pend_hi;
                    lo_q <= r_pend_lo;
                end
            end
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr);
        if (addr == 5'd0)
            return 32'd0;
        if (r_pend_valid && r_pend_kind == WB_GPR && r_pend_dest == addr)
            return r_pend_data;
        return r_gpr[addr];
    endfunction

    assign gr1 = read_port(rs_addr);
    assign gr2 = read_port(rt_addr);

endmodule
`default_nettype wire
